// File: rtl/camera_i2c_master.sv
// rtl/camera_i2c_master.sv - I2C master for 16-bit-address camera register reads and writes
// One bit slot is four SCL quarters; the slave may stretch SCL only at the rising edge in Q2.
module camera_i2c_master #(
  parameter int QDIV = 125
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rnw_i,
  input  logic [6:0]  req_dev_i,
  input  logic [15:0] req_reg_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_nack_o,
  output logic        busy_o,
  output logic        i2c_scl_out_o,
  output logic        i2c_scl_oen_o,
  input  logic        i2c_scl_in_i,
  output logic        i2c_sda_out_o,
  output logic        i2c_sda_oen_o,
  input  logic        i2c_sda_in_i
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG_H, S_REG_L, S_WDATA,
    S_RSTART, S_DEV_R, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [15:0] reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  shift_q, shift_d;
  logic        nack_q, nack_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_nack_q, rsp_nack_d;
  logic        scl_oen_q, scl_oen_d;
  logic        sda_oen_q, sda_oen_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic [7:0]  txb;

  logic scl_s, sda_s, tick, stall, sample, slot_end, byte_state;

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign tick       = (qcnt_q == QLAST);
  assign stall      = tick && (quarter_q == 2'd2) && !scl_s;
  assign sample     = tick && (quarter_q == 2'd2) && scl_s;
  assign slot_end   = tick && (quarter_q == 2'd3);
  assign byte_state = (state_q == S_DEV_W) || (state_q == S_REG_H) || (state_q == S_REG_L) ||
                      (state_q == S_WDATA) || (state_q == S_DEV_R) || (state_q == S_RDATA);

  always_comb begin : next_state
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    quarter_d   = quarter_q;
    bitcnt_d    = bitcnt_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    nack_d      = nack_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d   = S_START;
          qcnt_d    = '0;
          quarter_d = 2'd0;
          bitcnt_d  = 4'd0;
          rnw_d     = req_rnw_i;
          dev_d     = req_dev_i;
          reg_d     = req_reg_i;
          wdata_d   = req_wdata_i;
          shift_d   = 8'h00;
          nack_d    = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (!stall) begin
          qcnt_d = tick ? '0 : qcnt_q + CW'(1);
          if (tick) quarter_d = quarter_q + 2'd1;
        end
        // Q2 sample: read data bits in RDATA, the slave's ack bit in every transmit byte
        if (sample && byte_state) begin
          if (state_q == S_RDATA && bitcnt_q != 4'd8) shift_d = {shift_q[6:0], sda_s};
          if (state_q != S_RDATA && bitcnt_q == 4'd8 && sda_s) nack_d = 1'b1;
        end
        if (slot_end) begin
          case (state_q)
            S_START:  begin state_d = S_DEV_W; bitcnt_d = 4'd0; end
            S_RSTART: begin state_d = S_DEV_R; bitcnt_d = 4'd0; end
            S_STOP: begin
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
              rsp_nack_d  = nack_q;
              rsp_rdata_d = (rnw_q && !nack_q) ? shift_q : 8'h00;
            end
            default: begin
              if (bitcnt_q != 4'd8) begin
                bitcnt_d = bitcnt_q + 4'd1;
              end else begin
                bitcnt_d = 4'd0;
                if (nack_q) begin
                  state_d = S_STOP;
                end else begin
                  case (state_q)
                    S_DEV_W: state_d = S_REG_H;
                    S_REG_H: state_d = S_REG_L;
                    S_REG_L: state_d = rnw_q ? S_RSTART : S_WDATA;
                    S_DEV_R: state_d = S_RDATA;
                    default: state_d = S_STOP;
                  endcase
                end
              end
            end
          endcase
        end
      end
    endcase
  end

  // Pad enables are derived from the next state so SDA changes exactly at Q0 entry.
  always_comb begin : pad_next
    txb       = 8'hFF;
    scl_oen_d = 1'b1;
    sda_oen_d = 1'b1;
    case (state_d)
      S_DEV_W: txb = {dev_d, 1'b0};
      S_REG_H: txb = reg_d[15:8];
      S_REG_L: txb = reg_d[7:0];
      S_WDATA: txb = wdata_d;
      S_DEV_R: txb = {dev_d, 1'b1};
      default: txb = 8'hFF;
    endcase
    case (state_d)
      S_START: sda_oen_d = !quarter_d[1];
      S_RSTART: begin
        scl_oen_d = quarter_d[1];
        sda_oen_d = (quarter_d != 2'd3);
      end
      S_STOP: begin
        scl_oen_d = quarter_d[1];
        sda_oen_d = (quarter_d == 2'd3);
      end
      S_DEV_W, S_REG_H, S_REG_L, S_WDATA, S_DEV_R, S_RDATA: begin
        scl_oen_d = quarter_d[1];
        sda_oen_d = (state_d == S_RDATA || bitcnt_d == 4'd8) ? 1'b1 : txb[3'd7 - bitcnt_d[2:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      quarter_q   <= 2'd0;
      bitcnt_q    <= 4'd0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'h00;
      reg_q       <= 16'h0000;
      wdata_q     <= 8'h00;
      shift_q     <= 8'h00;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
      scl_oen_q   <= 1'b1;
      sda_oen_q   <= 1'b1;
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      quarter_q   <= quarter_d;
      bitcnt_q    <= bitcnt_d;
      rnw_q       <= rnw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
      scl_oen_q   <= scl_oen_d;
      sda_oen_q   <= sda_oen_d;
      scl_sync_q  <= {scl_sync_q[0], i2c_scl_in_i};
      sda_sync_q  <= {sda_sync_q[0], i2c_sda_in_i};
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_nack_o    = rsp_nack_q;
  assign i2c_scl_out_o = 1'b0;
  assign i2c_sda_out_o = 1'b0;
  assign i2c_scl_oen_o = scl_oen_q;
  assign i2c_sda_oen_o = sda_oen_q;

endmodule

// File: tb/tb_camera_i2c_master.sv
// tb/tb_camera_i2c_master.sv - directed vectors against a behavioural I2C slave with bus logger
// Log codes: 0..255 byte, 256 START, 257 RSTART, 258 STOP, 0x300|b master ack bit.
module tb_camera_i2c_master;
  localparam int QDIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rnw = 1'b0;
  logic [6:0]  req_dev = 7'h00;
  logic [15:0] req_reg = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_nack;
  logic        busy;
  logic        scl_out, scl_oen, sda_out, sda_oen;
  logic        scl_pad, sda_pad;

  logic        slave_sda_rel = 1'b1;
  logic        stretch_hold = 1'b0;
  int          cfg_nack_at = -1;
  logic [7:0]  cfg_rd = 8'h00;
  logic        cfg_stretch = 1'b0;
  int          clr_cnt = 0;

  int          log_ev[1024];
  int          log_wr = 0;
  int          exp_ev[32];
  int          exp_n;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign scl_pad = scl_oen & ~stretch_hold;
  assign sda_pad = sda_oen & slave_sda_rel;

  camera_i2c_master #(.QDIV(QDIV)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
    .req_dev_i(req_dev), .req_reg_i(req_reg), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_nack_o(rsp_nack),
    .busy_o(busy),
    .i2c_scl_out_o(scl_out), .i2c_scl_oen_o(scl_oen), .i2c_scl_in_i(scl_pad),
    .i2c_sda_out_o(sda_out), .i2c_sda_oen_o(sda_oen), .i2c_sda_in_i(sda_pad)
  );

  typedef struct {
    logic        rnw;
    logic [6:0]  dev;
    logic [15:0] rg;
    logic [7:0]  wd;
    int          nack_at;
    logic [7:0]  rd;
    logic        stretch;
    logic [7:0]  exp_rdata;
    logic        exp_nack;
    int          exp_slots;
  } vec_t;

  task automatic slave_push(input int val);
    if (log_wr < 1024) begin
      log_ev[log_wr] = val;
      log_wr++;
    end
  endtask

  // Slave: acks master bytes (NACKs byte index cfg_nack_at), returns cfg_rd after {dev,1}.
  initial begin : slave
    logic prev_scl, prev_sda, s, d, started, in_ack, reading, first_byte, ack_nacked;
    int bitcnt, byte_idx, falls, stretch_left, clr_seen;
    logic [7:0] shreg;
    prev_scl = 1'b1; prev_sda = 1'b1; started = 1'b0; in_ack = 1'b0; reading = 1'b0;
    first_byte = 1'b0; ack_nacked = 1'b0; bitcnt = 0; byte_idx = 0; falls = 0;
    stretch_left = 0; clr_seen = 0; shreg = 8'h00;
    forever begin
      @(negedge clk);
      s = scl_pad;
      d = sda_pad;
      if (clr_seen != clr_cnt) begin
        clr_seen = clr_cnt; started = 1'b0; in_ack = 1'b0; reading = 1'b0; first_byte = 1'b0;
        bitcnt = 0; byte_idx = 0; falls = 0; stretch_left = 0; slave_sda_rel = 1'b1;
      end
      if (prev_scl && s && prev_sda && !d) begin
        slave_push(started ? 257 : 256);
        started = 1'b1; bitcnt = 0; in_ack = 1'b0; first_byte = 1'b1; reading = 1'b0;
        falls = 0; slave_sda_rel = 1'b1;
      end else if (prev_scl && s && !prev_sda && d) begin
        slave_push(258);
        started = 1'b0; bitcnt = 0; in_ack = 1'b0; reading = 1'b0; byte_idx = 0;
        slave_sda_rel = 1'b1;
      end else if (!prev_scl && s) begin
        if (in_ack) begin
          if (reading && !first_byte) slave_push(32'h300 | int'(d));
        end else if (bitcnt < 8) begin
          shreg = {shreg[6:0], d};
          bitcnt++;
          if (bitcnt == 8) begin
            slave_push(int'(shreg));
            if (first_byte) reading = shreg[0];
          end
        end
      end else if (prev_scl && !s) begin
        falls++;
        if (cfg_stretch && falls == 13) stretch_left = 50;
        if (in_ack) begin
          in_ack = 1'b0;
          bitcnt = 0;
          if (ack_nacked || !first_byte) reading = 1'b0;
          first_byte = 1'b0;
          slave_sda_rel = reading ? cfg_rd[7] : 1'b1;
        end else if (bitcnt == 8) begin
          in_ack = 1'b1;
          if (reading && !first_byte) begin
            ack_nacked = 1'b0;
            slave_sda_rel = 1'b1;
          end else begin
            ack_nacked = (byte_idx == cfg_nack_at);
            slave_sda_rel = ack_nacked;
            byte_idx++;
          end
        end else if (reading && !first_byte) begin
          slave_sda_rel = cfg_rd[3'(7 - bitcnt)];
        end
      end
      prev_scl = s;
      prev_sda = d;
      stretch_hold = (stretch_left > 0);
      if (stretch_left > 0) stretch_left--;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int val);
    exp_ev[exp_n] = val;
    exp_n++;
  endtask

  task automatic build_exp(input vec_t v);
    exp_n = 0;
    exp_push(256);
    exp_push(int'({v.dev, 1'b0}));
    if (v.nack_at != 0) begin
      exp_push(int'(v.rg[15:8]));
      if (v.nack_at != 1) begin
        exp_push(int'(v.rg[7:0]));
        if (v.nack_at != 2) begin
          if (!v.rnw) begin
            exp_push(int'(v.wd));
          end else begin
            exp_push(257);
            exp_push(int'({v.dev, 1'b1}));
            if (v.nack_at != 3) begin
              exp_push(int'(v.rd));
              exp_push(32'h301);
            end
          end
        end
      end
    end
    exp_push(258);
  endtask

  task automatic do_txn(input vec_t v, input logic hold, input string tag);
    int n, pulses, base, mism, dlat, nominal;
    logic got;
    @(posedge clk); #1;
    cfg_nack_at = v.nack_at; cfg_rd = v.rd; cfg_stretch = v.stretch; clr_cnt++;
    @(posedge clk); #1;
    base = log_wr;
    build_exp(v);
    req_rnw = v.rnw; req_dev = v.dev; req_reg = v.rg; req_wdata = v.wd; req_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ready_after_accept"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    if (!hold) req_valid = 1'b0;
    n = 1;
    got = 1'b0;
    while (!got && n < 256 * QDIV) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (hold) begin
          req_rnw = 1'($urandom); req_dev = 7'($urandom);
          req_reg = 16'($urandom); req_wdata = 8'($urandom);
        end
        @(posedge clk); #1;
        n++;
      end
    end
    req_valid = 1'b0;
    chk({tag, "_completed"}, 32'(got), 32'd1);
    nominal = v.exp_slots * 4 * QDIV + 1;
    if (v.stretch) begin
      dlat = n - nominal;
      chk({tag, "_stretch_delay_1_to_50"}, 32'(dlat >= 1 && dlat <= 50), 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(n), 32'(nominal));
    end
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    chk({tag, "_nack"}, 32'(rsp_nack), 32'(v.exp_nack));
    pulses = got ? 1 : 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    chk({tag, "_rsp_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_rdata_held"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    chk({tag, "_idle_ready"}, 32'({req_ready, busy}), 32'b10);
    chk({tag, "_log_len"}, 32'(log_wr - base), 32'(exp_n));
    mism = 0;
    for (int i = 0; i < exp_n; i++)
      if (base + i >= 1024 || log_ev[base + i] != exp_ev[i]) mism++;
    chk({tag, "_log_bad_entries"}, 32'(mism), 32'd0);
  endtask

  initial begin : main
    vec_t vecs[7];
    vec_t wr0;
    int pulses;
    vecs[0] = '{1'b0, 7'h3C, 16'h3008, 8'h82, -1, 8'h00, 1'b0, 8'h00, 1'b0, 38};
    vecs[1] = '{1'b1, 7'h3C, 16'h300A, 8'h00, -1, 8'h56, 1'b0, 8'h56, 1'b0, 48};
    vecs[2] = '{1'b0, 7'h3C, 16'h3008, 8'h82,  0, 8'h00, 1'b0, 8'h00, 1'b1, 11};
    vecs[3] = '{1'b1, 7'h21, 16'h1234, 8'h00,  2, 8'hA5, 1'b0, 8'h00, 1'b1, 29};
    vecs[4] = '{1'b0, 7'h7F, 16'hFFFF, 8'h00, -1, 8'h00, 1'b0, 8'h00, 1'b0, 38};
    vecs[5] = '{1'b1, 7'h3C, 16'h300A, 8'h00,  3, 8'h56, 1'b0, 8'h00, 1'b1, 39};
    vecs[6] = '{1'b1, 7'h55, 16'h00FF, 8'h00, -1, 8'h01, 1'b0, 8'h01, 1'b0, 48};
    wr0 = vecs[0];

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_oen", 32'({scl_oen, sda_oen}), 32'b11);
    chk("reset_out", 32'({scl_out, sda_out}), 32'b00);
    chk("reset_ready_busy", 32'({req_ready, busy}), 32'b10);
    chk("reset_rsp", 32'({rsp_valid, rsp_nack, rsp_rdata}), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 7; i++) do_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

    wr0.stretch = 1'b1;
    do_txn(wr0, 1'b0, "stretch");
    wr0.stretch = 1'b0;
    do_txn(wr0, 1'b1, "hold_valid");

    @(posedge clk); #1;
    cfg_nack_at = -1; cfg_stretch = 1'b0; clr_cnt++;
    req_rnw = 1'b0; req_dev = 7'h3C; req_reg = 16'h3008; req_wdata = 8'h82; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (120 * QDIV - 1) @(posedge clk);
    #1;
    chk("midreset_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_oen", 32'({scl_oen, sda_oen}), 32'b11);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_ready", 32'(req_ready), 32'd1);
    pulses = 0;
    repeat (200) begin
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("midreset_no_rsp", 32'(pulses), 32'd0);
    do_txn(vecs[0], 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/camera_i2c_master.md
CAMERA_I2C_MASTER -- requirements
Module: camera_i2c_master

Interface
REQ-001 Parameter QDIV, default 125: system clocks per SCL quarter-period; legal minimum 4.
REQ-002 clk_i  input  1  system clock; all logic rising-edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req_valid_i  input  1  transaction request.
REQ-005 req_ready_o  output  1  high only in IDLE.
REQ-006 req_rnw_i  input  1  1 = register read, 0 = register write.
REQ-007 req_dev_i  input  7  7-bit device address.
REQ-008 req_reg_i  input  16  register address, sent MSB byte first.
REQ-009 req_wdata_i  input  8  write data.
REQ-010 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata_o  output  8  read data; held until next completion.
REQ-012 rsp_nack_o  output  1  slave NACK seen in transaction; held until next completion.
REQ-013 busy_o  output  1  high whenever state != IDLE.
REQ-014 i2c_scl_out_o / i2c_sda_out_o  output  1 each  constant 0 (open-drain).
REQ-015 i2c_scl_oen_o / i2c_sda_oen_o  output  1 each  0 = pull line low, 1 = release.
REQ-016 i2c_scl_in_i / i2c_sda_in_i  input  1 each  pad levels; each through a 2-FF synchronizer before use.

Function
REQ-017 Handshake: accept on the cycle req_valid_i && req_ready_o; latch all req fields; req_ready_o low from the next cycle; req_valid_i ignored outside IDLE.
REQ-018 Timing: quarter counter 0..QDIV-1, tick at QDIV-1; each bit slot = quarters Q0..Q3; first slot starts the cycle after accept.
REQ-019 Data slots: SCL low in Q0-Q1, released in Q2-Q3; SDA updated only at Q0 entry; SDA sampled on the Q2 tick.
REQ-020 Clock stretching: on the Q2 tick, if synchronized SCL is low, hold counter at QDIV-1 until it reads high; no other phase stalls.
REQ-021 States: IDLE, START, DEV_W, REG_H, REG_L, WDATA, RSTART, DEV_R, RDATA, STOP, DONE; each byte state = 8 data slots (MSB first) + 1 ack slot, bit counter 0..8.
REQ-022 START slot: SCL released all quarters; SDA released Q0-Q1, low Q2-Q3.
REQ-023 RSTART slot: SCL low Q0-Q1, released Q2-Q3; SDA released Q0-Q2, low Q3.
REQ-024 STOP slot: SDA low Q0-Q2, released Q3; SCL low Q0-Q1, released Q2-Q3.
REQ-025 Sequence: write = START, DEV_W {dev,0}, REG_H, REG_L, WDATA, STOP; read = START, DEV_W, REG_H, REG_L, RSTART, DEV_R {dev,1}, RDATA, STOP.
REQ-026 Transmit ack slot: SDA released; sampled 1 = NACK; sets nack flag and jumps to STOP after that slot.
REQ-027 RDATA: SDA released for 8 slots, sampled bits shifted MSB first; ack slot master NACK (SDA released).
REQ-028 DONE: one cycle, rsp_valid_o = 1, rsp_nack_o = flag, rsp_rdata_o = shifted byte (0x00 on write or NACK); then IDLE.
REQ-029 Latency without stretching: rsp_valid_o at A+1+152*QDIV (write, 38 slots) or A+1+192*QDIV (read, 48 slots), A = accept cycle.
REQ-030 Reset mid-transaction: next cycle both oen = 1, state IDLE, no STOP generated, no rsp_valid_o.

Reset
REQ-031 On rst_i: state IDLE, counters 0, i2c_scl_oen_o = 1, i2c_sda_oen_o = 1, out outputs 0, req_ready_o = 1, busy_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0x00, rsp_nack_o = 0.

Verification
REQ-032 Write dev=0x3C reg=0x3008 data=0x82, slave ACKs -> bus bytes 0x78, 0x30, 0x08, 0x82, STOP; rsp_nack_o = 0; rsp_valid_o at A+1+152*QDIV.
REQ-033 Read dev=0x3C reg=0x300A, slave returns 0x56 -> 0x78, 0x30, 0x0A, RSTART, 0x79, master NACK, STOP; rsp_rdata_o = 0x56, rsp_nack_o = 0, at A+1+192*QDIV.
REQ-034 Slave NACKs device byte -> STOP right after first ack slot; rsp_nack_o = 1, rsp_rdata_o = 0x00, rsp_valid_o at A+1+44*QDIV.
REQ-035 Slave holds SCL low 50 cycles during REG_H bit 3 -> no slot skipped, bytes unchanged, completion delayed by 1..50 cycles.
REQ-036 rst_i pulsed during WDATA -> next cycle oen outputs 1, busy_o 0, no rsp_valid_o; following write completes per REQ-032.
REQ-037 req_valid_i held high with changing fields while busy -> only the first request executes; exactly one rsp_valid_o pulse.
